// File: rtl/dac_link_pkg.sv
// dac_link_pkg: shared types and constants for the DAC SPI link frame scheduler.
// Holds the link FSM state encoding, the DAC power-state codes and the
// minimum sample-divider formula. Works with the optional build macro
// DAC_LINK_OVERRUN_CNT_EN used by dac_link_ctrl.

package dac_link_pkg;

   // Link FSM: IDLE waits for work, LOAD strobes the shifter, then the
   // chip select is followed low and back high before the link is free.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_LOW  = 2'd2,
      ST_WAIT_HIGH = 2'd3
   } link_state_e;

   // DAC power-state codes carried in every frame.
   localparam logic [1:0] PWR_NORMAL    = 2'b00;
   localparam logic [1:0] PWR_DOWN_1K   = 2'b01;
   localparam logic [1:0] PWR_DOWN_100K = 2'b10;
   localparam logic [1:0] PWR_DOWN_HIZ  = 2'b11;

   // Shortest sample period that still lets a whole frame (load, chip
   // select low for two words' worth of clocks, handshake back to idle)
   // finish before the next tick.
   function automatic int min_sample_div(input int word_width);
      return 2 * (word_width + 2) + 4;
   endfunction

endpackage

// File: rtl/dac_link_ctrl_rate_tick.sv
// dac_rate_tick: sample-rate divider for the DAC link.
// Counts 0..SAMPLE_DIV-1 while enabled and flags the last count as a tick.
// The counter is parked at zero while disabled so the first tick after
// enabling always lands a full period later.

module dac_rate_tick #(
   parameter int SAMPLE_DIV = 64
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic enable_i,
   output logic tick_o
);

   localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: hold at zero when disabled, wrap after the last count.
   always_comb begin
      count_d = count_q;
      if (!enable_i) begin
         count_d = '0;
      end else if (count_q == LAST) begin
         count_d = '0;
      end else begin
         count_d = count_q + CW'(1);
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_o = (count_q == LAST) && enable_i;

endmodule

// File: rtl/dac_link_ctrl.sv
// dac_link_ctrl: frame scheduler between the DDS sample stream and the SPI
// main shifter of the DAC link. Paces samples at SAMPLE_DIV, merges power
// state changes into frames and watches the shifter's chip select.
// Optional build macro DAC_LINK_OVERRUN_CNT_EN adds a saturating
// overrun_count output.

module dac_link_ctrl
   import dac_link_pkg::*;
#(
   parameter int         WORD_WIDTH = 16,
   parameter int         SAMPLE_DIV = 64,
   parameter logic [1:0] PWR_RESET  = PWR_NORMAL
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [WORD_WIDTH-1:0] sample_in,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   input  logic                  pwr_req,
   input  logic [1:0]            pwr_state_in,
   output logic                  pwr_ack,
   output logic                  spi_load,
   output logic [WORD_WIDTH-1:0] spi_word,
   output logic [1:0]            spi_power,
   input  logic                  spi_csb,
   output logic                  overrun,
`ifdef DAC_LINK_OVERRUN_CNT_EN
   output logic [15:0]           overrun_count,
`endif
   output logic                  underrun
);

   // A divider shorter than one frame would make every tick collide.
   if (SAMPLE_DIV < min_sample_div(WORD_WIDTH)) begin : g_div_check
      $error("dac_link_ctrl: SAMPLE_DIV too small for WORD_WIDTH");
   end

   logic tick;

   dac_rate_tick #(
      .SAMPLE_DIV(SAMPLE_DIV)
   ) u_rate_tick (
      .clk_i   (sys_clk),
      .rst_n_i (rst_n),
      .enable_i(enable),
      .tick_o  (tick)
   );

   link_state_e state_q, state_d;
   logic        launch;

   logic                  full_q, full_d;
   logic [WORD_WIDTH-1:0] hold_q, hold_d;
   logic [WORD_WIDTH-1:0] last_word_q, last_word_d;
   logic                  tick_pend_q, tick_pend_d;
   logic                  pwr_pend_q, pwr_pend_d;
   logic [1:0]            new_power_q, new_power_d;
   logic [1:0]            cur_power_q, cur_power_d;
   logic                  ready_q, ready_d;
   logic                  load_q, load_d;
   logic                  ack_q, ack_d;
   logic                  overrun_q, overrun_d;
   logic                  underrun_q, underrun_d;

   logic tick_frame;
   logic pwr_new;

   // FSM state register.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a frame only launches while the shifter is idle.
   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((tick_pend_q || tick || pwr_pend_q) && spi_csb) begin
               launch  = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_d = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            if (!spi_csb) begin
               state_d = ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (spi_csb) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign tick_frame = tick_pend_q || tick;
   assign pwr_new    = pwr_req && (pwr_state_in != cur_power_q) && !pwr_pend_q;

   // Datapath: sample holding, pending flags and frame contents at launch.
   // A fresh power request arriving in the launch cycle is folded into
   // that frame so a coincident tick and request give a single frame.
   always_comb begin
      full_d      = full_q;
      hold_d      = hold_q;
      last_word_d = last_word_q;
      tick_pend_d = tick_pend_q;
      pwr_pend_d  = pwr_pend_q;
      new_power_d = new_power_q;
      cur_power_d = cur_power_q;
      load_d      = 1'b0;
      ack_d       = 1'b0;
      overrun_d   = tick && tick_pend_q;
      underrun_d  = 1'b0;

      if (sample_valid && !full_q) begin
         full_d = 1'b1;
         hold_d = sample_in;
      end

      if (tick) begin
         tick_pend_d = 1'b1;
      end

      if (pwr_new) begin
         pwr_pend_d  = 1'b1;
         new_power_d = pwr_state_in;
      end

      if (launch) begin
         load_d      = 1'b1;
         tick_pend_d = 1'b0;
         if (tick_frame) begin
            if (full_q) begin
               last_word_d = hold_q;
               full_d      = 1'b0;
            end else begin
               underrun_d = 1'b1;
            end
         end
         if (pwr_pend_q) begin
            cur_power_d = new_power_q;
            pwr_pend_d  = 1'b0;
            ack_d       = 1'b1;
         end else if (pwr_new) begin
            cur_power_d = pwr_state_in;
            pwr_pend_d  = 1'b0;
            ack_d       = 1'b1;
         end
      end

      ready_d = !full_d;
   end

   // Datapath and output registers with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         full_q      <= 1'b0;
         hold_q      <= '0;
         last_word_q <= '0;
         tick_pend_q <= 1'b0;
         pwr_pend_q  <= 1'b0;
         new_power_q <= PWR_RESET;
         cur_power_q <= PWR_RESET;
         ready_q     <= 1'b1;
         load_q      <= 1'b0;
         ack_q       <= 1'b0;
         overrun_q   <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         full_q      <= full_d;
         hold_q      <= hold_d;
         last_word_q <= last_word_d;
         tick_pend_q <= tick_pend_d;
         pwr_pend_q  <= pwr_pend_d;
         new_power_q <= new_power_d;
         cur_power_q <= cur_power_d;
         ready_q     <= ready_d;
         load_q      <= load_d;
         ack_q       <= ack_d;
         overrun_q   <= overrun_d;
         underrun_q  <= underrun_d;
      end
   end

`ifdef DAC_LINK_OVERRUN_CNT_EN
   logic [15:0] ovr_count_q, ovr_count_d;

   // Saturating count of overrun pulses, aligned with the pulse output.
   always_comb begin
      ovr_count_d = ovr_count_q;
      if (overrun_d && (ovr_count_q != 16'hFFFF)) begin
         ovr_count_d = ovr_count_q + 16'd1;
      end
   end

   // Overrun counter register.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         ovr_count_q <= 16'd0;
      end else begin
         ovr_count_q <= ovr_count_d;
      end
   end

   assign overrun_count = ovr_count_q;
`endif

   // The word and power registers only change at launch, so they stay
   // stable for the shifter from LOAD until the next frame.
   assign sample_ready = ready_q;
   assign pwr_ack      = ack_q;
   assign spi_load     = load_q;
   assign spi_word     = last_word_q;
   assign spi_power    = cur_power_q;
   assign overrun      = overrun_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_dac_link_ctrl.sv
// tb_dac_link_ctrl: self-checking bench for dac_link_ctrl with a simple
// SPI main model that holds chip select low for 36 cycles per load.
// Build with DAC_LINK_OVERRUN_CNT_EN to also check overrun_count.

module tb_dac_link_ctrl;
   import dac_link_pkg::*;

   logic        sysClk;
   logic        rstN;
   logic        enable;
   logic [15:0] sampleIn;
   logic        sampleValid;
   logic        sampleReady;
   logic        pwrReq;
   logic [1:0]  pwrStateIn;
   logic        pwrAck;
   logic        spiLoad;
   logic [15:0] spiWord;
   logic [1:0]  spiPower;
   logic        spiCsb;
   logic        overrun;
   logic        underrun;
`ifdef DAC_LINK_OVERRUN_CNT_EN
   logic [15:0] overrunCount;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic forceLow = 1'b0;
   logic streamOn = 1'b0;
   int   busy = 0;

   int          loadCyc[$];
   logic [15:0] loadWord[$];
   logic [1:0]  loadPower[$];
   logic [15:0] acceptedQ[$];
   int          ackCnt;
   int          underrunCnt;
   int          overrunCnt;
   int          lastAckCyc;
   int          lastOvrCyc;

   dac_link_ctrl #(
      .WORD_WIDTH(16),
      .SAMPLE_DIV(64),
      .PWR_RESET (PWR_NORMAL)
   ) dut (
      .sys_clk      (sysClk),
      .rst_n        (rstN),
      .enable       (enable),
      .sample_in    (sampleIn),
      .sample_valid (sampleValid),
      .sample_ready (sampleReady),
      .pwr_req      (pwrReq),
      .pwr_state_in (pwrStateIn),
      .pwr_ack      (pwrAck),
      .spi_load     (spiLoad),
      .spi_word     (spiWord),
      .spi_power    (spiPower),
      .spi_csb      (spiCsb),
      .overrun      (overrun),
`ifdef DAC_LINK_OVERRUN_CNT_EN
      .overrun_count(overrunCount),
`endif
      .underrun     (underrun)
   );

   // Free-running system clock.
   initial begin
      sysClk = 1'b0;
      forever #5 sysClk = ~sysClk;
   end

   // Cycle index: cycle c is the interval after the c-th rising edge.
   initial begin
      forever begin
         @(posedge sysClk);
         cyc++;
      end
   end

   // SPI main model: chip select low for 36 cycles starting the cycle
   // after a load, or held low while forceLow is set.
   initial begin
      spiCsb = 1'b1;
      forever begin
         @(posedge sysClk);
         #1;
         if (busy > 0) begin
            spiCsb = 1'b0;
            busy--;
         end else begin
            spiCsb = 1'b1;
         end
         if (forceLow) spiCsb = 1'b0;
         if (spiLoad) busy = 36;
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n cycles, recording frames, pulses and accepted samples at
   // the falling edge, and refreshing the streamed sample after a handshake.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge sysClk);
         if (spiLoad) begin
            loadCyc.push_back(cyc);
            loadWord.push_back(spiWord);
            loadPower.push_back(spiPower);
         end
         if (pwrAck) begin
            ackCnt++;
            lastAckCyc = cyc;
         end
         if (underrun) underrunCnt++;
         if (overrun) begin
            overrunCnt++;
            lastOvrCyc = cyc;
         end
         if (sampleValid && sampleReady) begin
            acceptedQ.push_back(sampleIn);
            if (streamOn) sampleIn = 16'($urandom);
         end
         sampleValid = streamOn ? 1'b1 : sampleValid;
      end
   endtask

   task automatic clearMonitor();
      loadCyc.delete();
      loadWord.delete();
      loadPower.delete();
      acceptedQ.delete();
      ackCnt = 0;
      underrunCnt = 0;
      overrunCnt = 0;
      lastAckCyc = -1;
      lastOvrCyc = -1;
   endtask

   task automatic doReset();
      rstN = 1'b0;
      applyStimulus(1);
      rstN = 1'b1;
   endtask

   task automatic waitAck(input int target, input int budget, input string tag);
      int n = 0;
      while (ackCnt < target && n < budget) begin
         applyStimulus(1);
         n++;
      end
      checkOutput(tag, 32'(ackCnt >= target), 32'd1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_spi_load"}, 32'(spiLoad), 32'd0);
      checkOutput({tag, "_spi_word"}, 32'(spiWord), 32'd0);
      checkOutput({tag, "_spi_power"}, 32'(spiPower), 32'(PWR_NORMAL));
      checkOutput({tag, "_pwr_ack"}, 32'(pwrAck), 32'd0);
      checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
      checkOutput({tag, "_underrun"}, 32'(underrun), 32'd0);
      checkOutput({tag, "_sample_ready"}, 32'(sampleReady), 32'd1);
`ifdef DAC_LINK_OVERRUN_CNT_EN
      checkOutput({tag, "_overrun_count"}, 32'(overrunCount), 32'd0);
`endif
   endtask

   initial begin
      logic [15:0] w, s, t;
      logic [1:0]  p1, p2, p3, p4, p5;
      int          c0, k, l, e, r, n;

      rstN = 1'b0;
      enable = 1'b0;
      sampleIn = '0;
      sampleValid = 1'b0;
      pwrReq = 1'b0;
      pwrStateIn = 2'b00;
      clearMonitor();
      applyStimulus(3);
      checkResetOutputs("reset");

      // Streaming: every tick sends the next accepted sample, 64 cycles apart.
      $display("[TB] streaming phase");
      clearMonitor();
      rstN = 1'b1;
      enable = 1'b1;
      c0 = cyc;
      sampleIn = 16'($urandom);
      sampleValid = 1'b1;
      streamOn = 1'b1;
      applyStimulus(5 * 64 + 8);
      checkOutput("stream_nloads", 32'(loadCyc.size() >= 4), 32'd1);
      checkOutput("stream_first_cycle", (loadCyc.size() > 0) ? 32'(loadCyc[0]) : 32'hFFFFFFFF, 32'(c0 + 64));
      for (int i = 0; i < loadCyc.size(); i++) begin
         checkOutput($sformatf("stream_word%0d", i), 32'(loadWord[i]),
                     (i < acceptedQ.size()) ? 32'(acceptedQ[i]) : 32'hDEADBEEF);
         checkOutput($sformatf("stream_power%0d", i), 32'(loadPower[i]), 32'(PWR_NORMAL));
         if (i > 0) checkOutput($sformatf("stream_period%0d", i), 32'(loadCyc[i] - loadCyc[i-1]), 32'd64);
      end
      checkOutput("stream_underrun", 32'(underrunCnt), 32'd0);
      checkOutput("stream_overrun", 32'(overrunCnt), 32'd0);

      // Underrun: one sample then silence; the word repeats each tick.
      $display("[TB] underrun phase");
      streamOn = 1'b0;
      sampleValid = 1'b0;
      enable = 1'b0;
      applyStimulus(50);
      doReset();
      clearMonitor();
      w = 16'($urandom);
      sampleIn = w;
      sampleValid = 1'b1;
      applyStimulus(1);
      sampleValid = 1'b0;
      enable = 1'b1;
      c0 = cyc;
      applyStimulus(3 * 64 + 4);
      checkOutput("under_nloads", 32'(loadCyc.size()), 32'd3);
      for (int i = 0; i < loadCyc.size(); i++) begin
         checkOutput($sformatf("under_word%0d", i), 32'(loadWord[i]), 32'(w));
         checkOutput($sformatf("under_cycle%0d", i), 32'(loadCyc[i]), 32'(c0 + 64 * (i + 1)));
      end
      checkOutput("under_count", 32'(underrunCnt), 32'd2);
      checkOutput("under_overrun", 32'(overrunCnt), 32'd0);
      checkOutput("under_ready", 32'(sampleReady), 32'd1);

      // Power request from idle, then a second one while that frame runs.
      $display("[TB] power phase");
      enable = 1'b0;
      applyStimulus(50);
      clearMonitor();
      p1 = 2'($urandom_range(1, 3));
      p2 = p1 ^ 2'($urandom_range(1, 3));
      pwrStateIn = p1;
      pwrReq = 1'b1;
      k = cyc;
      waitAck(1, 20, "pwr_idle_ack_seen");
      checkOutput("pwr_idle_load_cycle", (loadCyc.size() > 0) ? 32'(loadCyc[0]) : 32'hFFFFFFFF, 32'(k + 2));
      checkOutput("pwr_idle_ack_cycle", 32'(lastAckCyc), 32'(k + 2));
      checkOutput("pwr_idle_power", (loadPower.size() > 0) ? 32'(loadPower[0]) : 32'hFFFFFFFF, 32'(p1));
      checkOutput("pwr_idle_word", (loadWord.size() > 0) ? 32'(loadWord[0]) : 32'hFFFFFFFF, 32'(w));
      l = cyc;
      pwrStateIn = p2;
      applyStimulus(1);
      checkOutput("pwr_mid_no_early_ack", 32'(ackCnt), 32'd1);
      waitAck(2, 80, "pwr_mid_ack_seen");
      pwrReq = 1'b0;
      checkOutput("pwr_mid_nloads", 32'(loadCyc.size()), 32'd2);
      checkOutput("pwr_mid_load_cycle", (loadCyc.size() > 1) ? 32'(loadCyc[1]) : 32'hFFFFFFFF, 32'(l + 39));
      checkOutput("pwr_mid_ack_cycle", 32'(lastAckCyc), 32'(l + 39));
      checkOutput("pwr_mid_power", (loadPower.size() > 1) ? 32'(loadPower[1]) : 32'hFFFFFFFF, 32'(p2));
      checkOutput("pwr_mid_word", (loadWord.size() > 1) ? 32'(loadWord[1]) : 32'hFFFFFFFF, 32'(w));
      applyStimulus(45);
      checkOutput("pwr_ack_total", 32'(ackCnt), 32'd2);

      // Power request in the tick cycle: one frame carrying both.
      $display("[TB] merged tick and power phase");
      clearMonitor();
      s = 16'($urandom);
      sampleIn = s;
      sampleValid = 1'b1;
      applyStimulus(1);
      sampleValid = 1'b0;
      p3 = p2 ^ 2'($urandom_range(1, 3));
      enable = 1'b1;
      e = cyc;
      applyStimulus(63);
      pwrStateIn = p3;
      pwrReq = 1'b1;
      applyStimulus(1);
      pwrReq = 1'b0;
      enable = 1'b0;
      applyStimulus(50);
      checkOutput("merge_nloads", 32'(loadCyc.size()), 32'd1);
      checkOutput("merge_cycle", (loadCyc.size() > 0) ? 32'(loadCyc[0]) : 32'hFFFFFFFF, 32'(e + 64));
      checkOutput("merge_word", (loadWord.size() > 0) ? 32'(loadWord[0]) : 32'hFFFFFFFF, 32'(s));
      checkOutput("merge_power", (loadPower.size() > 0) ? 32'(loadPower[0]) : 32'hFFFFFFFF, 32'(p3));
      checkOutput("merge_acks", 32'(ackCnt), 32'd1);
      checkOutput("merge_ack_cycle", 32'(lastAckCyc), 32'(e + 64));
      checkOutput("merge_underrun", 32'(underrunCnt), 32'd0);

      // Chip select forced low across two ticks: second tick overruns.
      $display("[TB] overrun phase");
      clearMonitor();
      t = 16'($urandom);
      sampleIn = t;
      sampleValid = 1'b1;
      applyStimulus(1);
      sampleValid = 1'b0;
      forceLow = 1'b1;
      enable = 1'b1;
      e = cyc;
      applyStimulus(130);
      enable = 1'b0;
      checkOutput("ovr_no_load", 32'(loadCyc.size()), 32'd0);
      checkOutput("ovr_count_pulses", 32'(overrunCnt), 32'd1);
      checkOutput("ovr_pulse_cycle", 32'(lastOvrCyc), 32'(e + 128));
`ifdef DAC_LINK_OVERRUN_CNT_EN
      checkOutput("ovr_counter", 32'(overrunCount), 32'd1);
`endif
      r = cyc;
      forceLow = 1'b0;
      applyStimulus(45);
      checkOutput("ovr_release_nloads", 32'(loadCyc.size()), 32'd1);
      checkOutput("ovr_release_cycle", (loadCyc.size() > 0) ? 32'(loadCyc[0]) : 32'hFFFFFFFF, 32'(r + 2));
      checkOutput("ovr_release_word", (loadWord.size() > 0) ? 32'(loadWord[0]) : 32'hFFFFFFFF, 32'(t));
      checkOutput("ovr_release_power", (loadPower.size() > 0) ? 32'(loadPower[0]) : 32'hFFFFFFFF, 32'(p3));
      checkOutput("ovr_release_overrun", 32'(overrunCnt), 32'd1);

      // Reset mid-frame with chip select low: nothing launches until it rises.
      $display("[TB] reset mid-frame phase");
      clearMonitor();
      p4 = p3 ^ 2'($urandom_range(1, 3));
      pwrStateIn = p4;
      pwrReq = 1'b1;
      waitAck(1, 20, "rst_first_ack_seen");
      pwrReq = 1'b0;
      l = cyc;
      sampleIn = 16'($urandom);
      sampleValid = 1'b1;
      applyStimulus(1);
      sampleValid = 1'b0;
      applyStimulus(3);
      rstN = 1'b0;
      applyStimulus(1);
      checkResetOutputs("midreset");
      rstN = 1'b1;
      p5 = 2'($urandom_range(1, 3));
      pwrStateIn = p5;
      pwrReq = 1'b1;
      n = 0;
      while (loadCyc.size() < 2 && n < 100) begin
         applyStimulus(1);
         n++;
      end
      pwrReq = 1'b0;
      checkOutput("rst_relaunch_seen", 32'(loadCyc.size()), 32'd2);
      checkOutput("rst_relaunch_cycle", (loadCyc.size() > 1) ? 32'(loadCyc[1]) : 32'hFFFFFFFF, 32'(l + 38));
      checkOutput("rst_relaunch_power", (loadPower.size() > 1) ? 32'(loadPower[1]) : 32'hFFFFFFFF, 32'(p5));
      checkOutput("rst_relaunch_word", (loadWord.size() > 1) ? 32'(loadWord[1]) : 32'hFFFFFFFF, 32'd0);
      checkOutput("rst_relaunch_ack", 32'(lastAckCyc), 32'(l + 38));
      applyStimulus(45);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
